// File: rtl/step_pulse_decoder_if.sv
// Step/dir receive bus for step_pulse_decoder.
// master: the side driving step/dir and the control inputs (bench or host).
// slave:  the decoder itself.
interface step_pulse_decoder_if #(
   parameter int unsigned width       = 32,
   parameter int unsigned count_width = 32
);
   logic                   step_in;
   logic                   dir_in;
   logic                   write;
   logic [count_width-1:0] min_high_count;
   logic [count_width-1:0] min_low_count;
   logic                   clear_position;
   logic                   clear_errors;
   logic [width-1:0]       position;
   logic [count_width-1:0] pulse_width;
   logic                   step_strobe;
   logic                   width_error;
   logic                   dwell_error;
   logic                   busy;

   modport master (
      output step_in, dir_in, write, min_high_count, min_low_count,
             clear_position, clear_errors,
      input  position, pulse_width, step_strobe, width_error, dwell_error, busy
   );

   modport slave (
      input  step_in, dir_in, write, min_high_count, min_low_count,
             clear_position, clear_errors,
      output position, pulse_width, step_strobe, width_error, dwell_error, busy
   );
endinterface

// File: rtl/step_pulse_decoder.sv
// Step/dir receive decoder: synchronizes an external step/dir pair, tracks signed
// position, measures pulse high width and low dwell, and flags timing violations.
// Optional build macro STEP_PULSE_DECODER_FILTER_EN: pulses failing the width
// check are rejected (no position change, no strobe). Default: all pulses counted.
module step_pulse_decoder #(
   parameter int unsigned width       = 32,
   parameter int unsigned count_width = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                 clock_in,
   input logic                 reset_n,
   step_pulse_decoder_if.slave bus
);

   typedef enum logic [1:0] {StWaitLow, StLow, StHigh} state_e;

   localparam logic [count_width-1:0] CountMax = '1;
   localparam logic [count_width-1:0] CountOne = count_width'(1);

   logic [SYNC_STAGES-1:0] r_step_sync;
   logic [SYNC_STAGES-1:0] r_dir_sync;
   logic [SYNC_STAGES-1:0] r_prime;
   logic                   r_step_dly;

   state_e                 r_state, w_state_nxt;
   logic [count_width-1:0] r_low_count, w_low_count_nxt;
   logic [count_width-1:0] r_high_count, w_high_count_nxt;
   logic [count_width-1:0] r_pulse_width, w_pulse_width_nxt;
   logic [count_width-1:0] r_min_high, r_min_low;
   logic [width-1:0]       r_position, w_position_nxt;
   logic                   r_dir_latch, w_dir_latch_nxt;
   logic                   r_strobe, w_strobe_nxt;
   logic                   r_width_err, w_width_err_nxt;
   logic                   r_dwell_err, w_dwell_err_nxt;

   logic w_step, w_dir, w_primed, w_rise, w_fall;
   logic w_width_short, w_dwell_short, w_accept_ok;
   logic w_accept, w_new_width_err, w_new_dwell_err;

   assign w_step   = r_step_sync[SYNC_STAGES-1];
   assign w_dir    = r_dir_sync[SYNC_STAGES-1];
   // Synced step only reflects real input once every stage has been reloaded after
   // reset; without this a pulse already high at reset release would look like a
   // fresh rising edge.
   assign w_primed = r_prime[SYNC_STAGES-1];
   assign w_rise   = w_step & ~r_step_dly;
   assign w_fall   = ~w_step & r_step_dly;

   assign w_width_short = (r_min_high != '0) && (r_high_count < r_min_high);
   assign w_dwell_short = (r_min_low != '0) && (r_low_count < r_min_low);

`ifdef STEP_PULSE_DECODER_FILTER_EN
   assign w_accept_ok = ~w_width_short;
`else
   assign w_accept_ok = 1'b1;
`endif

   // Input synchronizers, edge-detect delay and synchronizer-primed tracking.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_step_sync <= '0;
         r_dir_sync  <= '0;
         r_prime     <= '0;
         r_step_dly  <= 1'b0;
      end else begin
         r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], bus.step_in};
         r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], bus.dir_in};
         r_prime     <= {r_prime[SYNC_STAGES-2:0], 1'b1};
         r_step_dly  <= w_step;
      end
   end

   // Programmable minimum limits.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_min_high <= '0;
         r_min_low  <= '0;
      end else if (bus.write) begin
         r_min_high <= bus.min_high_count;
         r_min_low  <= bus.min_low_count;
      end
   end

   // Next-state logic: pulse FSM, width/dwell counters and step acceptance.
   always_comb begin
      w_state_nxt       = r_state;
      w_low_count_nxt   = r_low_count;
      w_high_count_nxt  = r_high_count;
      w_pulse_width_nxt = r_pulse_width;
      w_dir_latch_nxt   = r_dir_latch;
      w_accept          = 1'b0;
      w_new_width_err   = 1'b0;
      w_new_dwell_err   = 1'b0;
      unique case (r_state)
         StWaitLow: begin
            if (w_primed && !w_step) begin
               w_state_nxt     = StLow;
               // Saturated dwell so the first pulse never flags a dwell error.
               w_low_count_nxt = CountMax;
            end
         end
         StLow: begin
            if (w_rise) begin
               w_new_dwell_err  = w_dwell_short;
               w_dir_latch_nxt  = w_dir;
               w_high_count_nxt = CountOne;
               w_state_nxt      = StHigh;
            end else if (r_low_count != CountMax) begin
               w_low_count_nxt = r_low_count + CountOne;
            end
         end
         StHigh: begin
            if (w_fall) begin
               w_pulse_width_nxt = r_high_count;
               w_new_width_err   = w_width_short;
               w_accept          = w_accept_ok;
               w_low_count_nxt   = CountOne;
               w_state_nxt       = StLow;
            end else if (r_high_count != CountMax) begin
               w_high_count_nxt = r_high_count + CountOne;
            end
         end
         default: w_state_nxt = StWaitLow;
      endcase

      // Clear wins over an accepted step; the strobe still reports the step.
      w_position_nxt = r_position;
      if (bus.clear_position) begin
         w_position_nxt = '0;
      end else if (w_accept) begin
         w_position_nxt = r_dir_latch ? (r_position + width'(1)) : (r_position - width'(1));
      end
      w_strobe_nxt = w_accept;

      // A new error in the clearing cycle keeps the flag set.
      w_width_err_nxt = (r_width_err & ~bus.clear_errors) | w_new_width_err;
      w_dwell_err_nxt = (r_dwell_err & ~bus.clear_errors) | w_new_dwell_err;
   end

   // State, counter and output registers.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= StWaitLow;
         r_low_count   <= '0;
         r_high_count  <= '0;
         r_pulse_width <= '0;
         r_dir_latch   <= 1'b0;
         r_position    <= '0;
         r_strobe      <= 1'b0;
         r_width_err   <= 1'b0;
         r_dwell_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_low_count   <= w_low_count_nxt;
         r_high_count  <= w_high_count_nxt;
         r_pulse_width <= w_pulse_width_nxt;
         r_dir_latch   <= w_dir_latch_nxt;
         r_position    <= w_position_nxt;
         r_strobe      <= w_strobe_nxt;
         r_width_err   <= w_width_err_nxt;
         r_dwell_err   <= w_dwell_err_nxt;
      end
   end

   assign bus.position    = r_position;
   assign bus.pulse_width = r_pulse_width;
   assign bus.step_strobe = r_strobe;
   assign bus.width_error = r_width_err;
   assign bus.dwell_error = r_dwell_err;
   assign bus.busy        = (r_state == StHigh);

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Bench for step_pulse_decoder: a run-length model of the sampled step waveform
// predicts every output each cycle; directed literal checks pin the model.
module tb_step_pulse_decoder;

   localparam int unsigned W    = 32;
   localparam int unsigned CW   = 32;
   localparam int unsigned SYNC = 2;
   localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

   logic clock_in = 1'b0;
   logic reset_n  = 1'b0;

   step_pulse_decoder_if #(.width(W), .count_width(CW)) bus ();

   step_pulse_decoder #(
      .width      (W),
      .count_width(CW),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clock_in(clock_in),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock_in = ~clock_in;

`ifdef STEP_PULSE_DECODER_FILTER_EN
   localparam bit Filter = 1'b1;
`else
   localparam bit Filter = 1'b0;
`endif

   // ---------------- model ----------------
   // Raw samples wait SYNC cycles (synchronizer latency), then the waveform is
   // viewed as alternating runs: a run of 1s is a pulse, a run of 0s is a dwell.
   bit               q_step[$];
   bit               q_dir[$];
   bit               m_seen_low;   // a real low has been seen since reset
   bit               m_prev;       // value of the current run
   longint unsigned  m_run;        // length of the current run, saturating
   bit               m_rise_dir;
   longint unsigned  m_min_high, m_min_low;
   logic [W-1:0]     exp_position;
   logic [CW-1:0]    exp_pw;
   bit               exp_strobe, exp_werr, exp_derr, exp_busy;

   always @(posedge clock_in or negedge reset_n) begin
      bit v, d, acc, nw, nd;
      if (!reset_n) begin
         q_step.delete();
         q_dir.delete();
         m_seen_low = 0; m_prev = 0; m_run = 0; m_rise_dir = 0;
         m_min_high = 0; m_min_low = 0;
         exp_position = '0; exp_pw = '0;
         exp_strobe = 0; exp_werr = 0; exp_derr = 0; exp_busy = 0;
      end else begin
         acc = 0; nw = 0; nd = 0;
         q_step.push_back(bus.step_in);
         q_dir.push_back(bus.dir_in);
         if (q_step.size() > SYNC) begin
            v = q_step.pop_front();
            d = q_dir.pop_front();
            if (!m_seen_low) begin
               if (!v) begin
                  m_seen_low = 1; m_prev = 0; m_run = CMAX;
               end
            end else if (v == m_prev) begin
               if (m_run < CMAX) m_run++;
            end else begin
               if (v) begin
                  nd = (m_min_low != 0) && (m_run < m_min_low);
                  m_rise_dir = d;
               end else begin
                  exp_pw = CW'(m_run);
                  nw = (m_min_high != 0) && (m_run < m_min_high);
                  acc = Filter ? !nw : 1'b1;
               end
               m_prev = v;
               m_run = 1;
            end
         end
         exp_strobe = acc;
         if (bus.clear_position) exp_position = '0;
         else if (acc) exp_position = m_rise_dir ? exp_position + 1 : exp_position - 1;
         exp_werr = (exp_werr && !bus.clear_errors) || nw;
         exp_derr = (exp_derr && !bus.clear_errors) || nd;
         exp_busy = m_seen_low && m_prev;
         if (bus.write) begin
            m_min_high = bus.min_high_count;
            m_min_low  = bus.min_low_count;
         end
      end
   end

   // ---------------- checking ----------------
   int n_tests   = 0;
   int n_fail    = 0;
   int n_strobes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      check("cyc position", bus.position, exp_position);
      check("cyc pulse_width", bus.pulse_width, exp_pw);
      check("cyc step_strobe", bus.step_strobe, exp_strobe);
      check("cyc width_error", bus.width_error, exp_werr);
      check("cyc dwell_error", bus.dwell_error, exp_derr);
      check("cyc busy", bus.busy, exp_busy);
   endtask

   // Advance n cycles; outputs are compared on each falling edge.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock_in);
         compare();
         if (bus.step_strobe) n_strobes++;
      end
   endtask

   task automatic pulse(input int high, input int low, input bit dir);
      bus.dir_in  = dir;
      bus.step_in = 1'b1;
      cyc(high);
      bus.step_in = 1'b0;
      cyc(low);
   endtask

   task automatic write_min(input int hi, input int lo);
      bus.min_high_count = CW'(hi);
      bus.min_low_count  = CW'(lo);
      bus.write = 1'b1;
      cyc(1);
      bus.write = 1'b0;
   endtask

   task automatic clear_pos();
      bus.clear_position = 1'b1;
      cyc(1);
      bus.clear_position = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s0;
      bus.step_in = 0; bus.dir_in = 0; bus.write = 0;
      bus.min_high_count = '0; bus.min_low_count = '0;
      bus.clear_position = 0; bus.clear_errors = 0;
      reset_n = 0;
      cyc(3);
      check("reset position", bus.position, 0);
      check("reset busy", bus.busy, 0);
      reset_n = 1;
      cyc(5);
      pulse(4, 6, 1);
      check("first pulse position", bus.position, 1);

      // Asynchronous reset mid-simulation with step low.
      reset_n = 0;
      #1;
      check("async reset position", bus.position, 0);
      check("async reset pulse_width", bus.pulse_width, 0);
      check("async reset busy", bus.busy, 0);
      cyc(2);
      reset_n = 1;
      cyc(5);
      pulse(4, 6, 1);
      check("post reset position", bus.position, 1);

      // Nominal: three 4/6 pulses with limits 4/4.
      clear_pos();
      write_min(4, 4);
      cyc(6);
      s0 = n_strobes;
      pulse(4, 6, 1);
      pulse(4, 6, 1);
      bus.step_in = 1'b1;
      cyc(4);
      bus.step_in = 1'b0;
      cyc(2);
      check("strobe before edge 3", bus.step_strobe, 0);
      cyc(1);
      check("strobe on edge 3", bus.step_strobe, 1);
      cyc(5);
      check("nominal position", bus.position, 3);
      check("nominal strobes", n_strobes - s0, 3);
      check("nominal pulse_width", bus.pulse_width, 4);
      check("nominal width_error", bus.width_error, 0);
      check("nominal dwell_error", bus.dwell_error, 0);

      // Reverse and wrap.
      clear_pos();
      pulse(4, 6, 0);
      pulse(4, 6, 0);
      check("reverse wrap position", bus.position, 64'hFFFF_FFFE);
      pulse(4, 6, 1);
      pulse(4, 6, 1);
      check("forward back to zero", bus.position, 0);

      // Short pulse against min_high=4.
      clear_pos();
      pulse(2, 6, 1);
      check("short width_error", bus.width_error, 1);
      check("short pulse_width", bus.pulse_width, 2);
      check("short position", bus.position, Filter ? 0 : 1);
      bus.clear_errors = 1'b1;
      cyc(1);
      bus.clear_errors = 1'b0;
      check("width_error cleared", bus.width_error, 0);

      // Dwell violation with min_low=10.
      write_min(0, 10);
      clear_pos();
      cyc(12);
      pulse(4, 3, 1);
      pulse(4, 8, 1);
      check("dwell_error set", bus.dwell_error, 1);
      check("dwell position", bus.position, 2);
      // Clear lands in the same cycle as the next violation is detected.
      bus.step_in = 1'b1;
      cyc(2);
      bus.clear_errors = 1'b1;
      cyc(1);
      bus.clear_errors = 1'b0;
      cyc(1);
      bus.step_in = 1'b0;
      cyc(6);
      check("dwell_error held over clear", bus.dwell_error, 1);
      check("dwell position 3", bus.position, 3);

      // Reset during a pulse; released while step is still high.
      write_min(0, 0);
      cyc(12);
      bus.step_in = 1'b1;
      cyc(3);
      check("busy mid pulse", bus.busy, 1);
      reset_n = 0;
      cyc(2);
      reset_n = 1;
      s0 = n_strobes;
      cyc(5);
      bus.step_in = 1'b0;
      cyc(6);
      check("partial pulse strobes", n_strobes - s0, 0);
      check("partial pulse position", bus.position, 0);
      pulse(4, 6, 1);
      check("after partial position", bus.position, 1);

      // clear_position in the same cycle as an accepted step.
      bus.step_in = 1'b1;
      cyc(4);
      bus.step_in = 1'b0;
      cyc(2);
      bus.clear_position = 1'b1;
      cyc(1);
      bus.clear_position = 1'b0;
      check("clear vs step strobe", bus.step_strobe, 1);
      check("clear vs step position", bus.position, 0);
      cyc(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
